// File: rtl/force_accumulator_if.sv
// Bus bundle for force_accumulator: force-triple handshake, clear/busy control
// and the registered readback port.
interface force_accumulator_if #(
  parameter int IDX_W = 6
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_ref_idx;
  logic [IDX_W-1:0] in_nbr_idx;
  logic [95:0]      in_force;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic [95:0]      rd_force;
  logic             busy;

  modport master (
    output clear, in_valid, in_ref_idx, in_nbr_idx, in_force, rd_en, rd_idx,
    input  in_ready, rd_valid, rd_force, busy
  );

  modport slave (
    input  clear, in_valid, in_ref_idx, in_nbr_idx, in_force, rd_en, rd_idx,
    output in_ready, rd_valid, rd_force, busy
  );
endinterface

// File: rtl/force_accumulator.sv
// Per-particle fp32 force accumulator: +F into the reference slot, -F into the
// neighbor slot one cycle later, with a clear sweep and a registered readback.
module force_accumulator #(
  parameter int NUM_PARTICLES = 64,
  parameter int IDX_W         = 6
) (
  input logic                clk,
  input logic                rst_n,
  force_accumulator_if.slave bus
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_NBR} state_t;

  localparam logic [IDX_W:0]   NP        = (IDX_W+1)'(NUM_PARTICLES);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_PARTICLES - 1);
  localparam logic [95:0]      SIGN_MASK = {1'b1, 31'd0, 1'b1, 31'd0, 1'b1, 31'd0};

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NP;
  endfunction

  // fp32 add, round-to-nearest-even; subnormal operands are treated as zero.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0]       a, b;
    logic [26:0]       ma, mb, mbs, m;
    logic [27:0]       s;
    logic [7:0]        d;
    logic [23:0]       r;
    logic signed [9:0] e;
    logic              sticky, up;
    if (x[30:23] == 8'd0) return y;
    if (y[30:23] == 8'd0) return x;
    if (x[30:0] >= y[30:0]) begin a = x; b = y; end
    else                    begin a = y; b = x; end
    d      = a[30:23] - b[30:23];
    ma     = {1'b1, a[22:0], 3'b000};
    mb     = {1'b1, b[22:0], 3'b000};
    mbs    = mb >> d;
    sticky = ((mbs << d) != mb);
    mbs[0] = mbs[0] | sticky;
    e      = {2'b00, a[30:23]};
    if (a[31] == b[31]) begin
      s = {1'b0, ma} + {1'b0, mbs};
      if (s[27]) begin
        m    = s[27:1];
        m[0] = m[0] | s[0];
        e    = e + 10'sd1;
      end else begin
        m = s[26:0];
      end
    end else begin
      m = ma - mbs;
      if (m == 27'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!m[26]) begin
          m = m << 1;
          e = e - 10'sd1;
        end
      end
    end
    up = m[2] & (m[1] | m[0] | m[3]);
    r  = {1'b0, m[25:3]} + {23'd0, up};
    if (r[23]) e = e + 10'sd1;
    if (e <= 10'sd0)   return {a[31], 31'd0};
    if (e >= 10'sd255) return {a[31], 8'hFF, 23'd0};
    return {a[31], e[7:0], r[22:0]};
  endfunction

  logic [95:0]      mem [NUM_PARTICLES];
  state_t           state_reg, state_next;
  logic [IDX_W-1:0] sweep_ptr_reg, sweep_ptr_next;
  logic [IDX_W-1:0] nbr_idx_reg, nbr_idx_next;
  logic [95:0]      force_reg, force_next;
  logic             rd_valid_reg;
  logic [95:0]      rd_force_reg;

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [95:0]      wdata;
  logic [IDX_W-1:0] acc_idx;
  logic [95:0]      acc_base, acc_force, acc_sum;

  // One adder set serves both phases: ref (+F from the bus) then nbr (-F latched).
  assign acc_idx   = (state_reg == S_NBR) ? nbr_idx_reg : bus.in_ref_idx;
  assign acc_base  = in_range(acc_idx) ? mem[acc_idx] : '0;
  assign acc_force = (state_reg == S_NBR) ? (force_reg ^ SIGN_MASK) : bus.in_force;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_add
      assign acc_sum[gi*32 +: 32] = fp_add(acc_base[gi*32 +: 32], acc_force[gi*32 +: 32]);
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    sweep_ptr_next = sweep_ptr_reg;
    nbr_idx_next   = nbr_idx_reg;
    force_next     = force_reg;
    we             = 1'b0;
    waddr          = sweep_ptr_reg;
    wdata          = '0;
    case (state_reg)
      S_CLEAR: begin
        we = 1'b1;
        if (bus.clear) begin
          sweep_ptr_next = '0;
        end else if (sweep_ptr_reg == LAST_SLOT) begin
          sweep_ptr_next = '0;
          state_next     = S_IDLE;
        end else begin
          sweep_ptr_next = sweep_ptr_reg + IDX_W'(1);
        end
      end
      S_IDLE: begin
        if (bus.clear) begin
          sweep_ptr_next = '0;
          state_next     = S_CLEAR;
        end else if (bus.in_valid && (bus.in_ref_idx != bus.in_nbr_idx)) begin
          nbr_idx_next = bus.in_nbr_idx;
          force_next   = bus.in_force;
          we           = in_range(bus.in_ref_idx);
          waddr        = bus.in_ref_idx;
          wdata        = acc_sum;
          state_next   = S_NBR;
        end
      end
      S_NBR: begin
        // A clear arriving here is deferred until this write has landed.
        we             = in_range(nbr_idx_reg);
        waddr          = nbr_idx_reg;
        wdata          = acc_sum;
        sweep_ptr_next = '0;
        state_next     = bus.clear ? S_CLEAR : S_IDLE;
      end
      default: state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_CLEAR;
      sweep_ptr_reg <= '0;
      nbr_idx_reg   <= '0;
      force_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      rd_force_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_ptr_reg <= sweep_ptr_next;
      nbr_idx_reg   <= nbr_idx_next;
      force_reg     <= force_next;
      rd_valid_reg  <= bus.rd_en;
      if (bus.rd_en) rd_force_reg <= in_range(bus.rd_idx) ? mem[bus.rd_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.in_ready = (state_reg == S_IDLE) && !bus.clear;
  assign bus.busy     = (state_reg == S_CLEAR);
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_force = rd_force_reg;

endmodule
